dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port, word-wide data memory (`data_mem`, synchronous read and write, read register updated only when not writing). It shares the memory between the core load/store unit (port 0) and the debug/DMA port (port 1) using round-robin arbitration. It converts byte, halfword and word requests into memory cycles, using read-modify-write for sub-word stores. It sign- or zero-extends load data and flags misaligned or out-of-range accesses.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lane.sv | 36 +++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory arbiter.
// Access size codes and the sequencer state enum.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MERGE,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: byte/halfword lane extract with extension for loads,
// and lane merge of store data into a read word for sub-word stores.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{off, 3'b000} +: 8];
        half_lane = rdata[{off[1], 4'b0000} +: 16];
        unique case (size)
            SZ_B:    load_data = {{24{~uns & byte_lane[7]}}, byte_lane};
            SZ_H:    load_data = {{16{~uns & half_lane[15]}}, half_lane};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        if (size == SZ_B)
            merge_data[{off, 3'b000} +: 8] = wdata[7:0];
        else
            merge_data[{off[1], 4'b0000} +: 16] = wdata;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for the single-port data
// memory, with read-modify-write sub-word stores and load extension.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEMORY_SIZE = 2048,
    parameter int ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [1:0]            p0_size,
    input  logic                  p0_uns,
    input  logic [31:0]           p0_addr,
    input  logic [31:0]           p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_err,
    output logic [31:0]           p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [1:0]            p1_size,
    input  logic                  p1_uns,
    input  logic [31:0]           p1_addr,
    input  logic [31:0]           p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_err,
    output logic [31:0]           p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    state_t                state, state_nx;
    logic                  last_grant;
    logic                  go, sel;
    logic                  cur_we, cur_uns, cur_err;
    logic [1:0]            cur_size;
    logic [31:0]           cur_addr, cur_wdata;
    logic                  gnt_q, uns_q, err_q;
    logic [1:0]            size_q, off_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [15:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [31:0]           load_data, merge_data;

    // Grant is gated by rst_n so nothing reaches memory while reset is held.
    assign go  = rst_n & (p0_req | p1_req);
    assign sel = p1_req & (~p0_req | ~last_grant);

    always_comb begin
        cur_we    = sel ? p1_we    : p0_we;
        cur_size  = sel ? p1_size  : p0_size;
        cur_uns   = sel ? p1_uns   : p0_uns;
        cur_addr  = sel ? p1_addr  : p0_addr;
        cur_wdata = sel ? p1_wdata : p0_wdata;
    end

    assign cur_err = (cur_size == 2'b11)
                   | ((cur_size == SZ_H) & cur_addr[0])
                   | ((cur_size == SZ_W) & (cur_addr[1:0] != 2'b00))
                   | ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (go) begin
                    if (cur_err || (cur_we && cur_size == SZ_W))
                        state_nx = RESP;
                    else if (cur_we)
                        state_nx = MERGE;
                    else
                        state_nx = LOAD;
                end
            end
            LOAD:  state_nx = RESP;
            MERGE: state_nx = RESP;
            RESP:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (go && !cur_err) begin
                    mem_addr = cur_addr[ADDR_WIDTH+1:2];
                    if (cur_we && cur_size == SZ_W) begin
                        mem_we    = 1'b1;
                        mem_wdata = cur_wdata;
                    end else begin
                        mem_re = 1'b1;
                    end
                end
            end
            MERGE: begin
                mem_addr  = waddr_q;
                mem_we    = 1'b1;
                mem_wdata = merge_data;
            end
            default: ;
        endcase
    end

    assign p0_ack   = (state == RESP) & ~gnt_q;
    assign p1_ack   = (state == RESP) & gnt_q;
    assign p0_err   = p0_ack & err_q;
    assign p1_err   = p1_ack & err_q;
    assign p0_rdata = p0_ack ? rdata_q : '0;
    assign p1_rdata = p1_ack ? rdata_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            off_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else if (state == IDLE && go) begin
            last_grant <= sel;
            gnt_q      <= sel;
            size_q     <= cur_size;
            uns_q      <= cur_uns;
            off_q      <= cur_addr[1:0];
            waddr_q    <= cur_addr[ADDR_WIDTH+1:2];
            wdata_q    <= cur_wdata[15:0];
            err_q      <= cur_err;
            rdata_q    <= '0;
        end else if (state == LOAD) begin
            rdata_q <= load_data;
        end
    end

    dmem_lane u_lane (
        .size       (size_q),
        .uns        (uns_q),
        .off        (off_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, abort/contention sequences and random
// traffic checked against a byte-array reference model.
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 2048;
    localparam int AW        = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p0_uns;
    logic [1:0]    p0_size;
    logic [31:0]   p0_addr, p0_wdata;
    logic          p0_ack, p0_err;
    logic [31:0]   p0_rdata;
    logic          p1_req, p1_we, p1_uns;
    logic [1:0]    p1_size;
    logic [31:0]   p1_addr, p1_wdata;
    logic          p1_ack, p1_err;
    logic [31:0]   p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0] tmem [MEM_WORDS] = '{default: 32'h0};
    logic [31:0] tmem_rd = 32'h0;
    logic [7:0]  rb [4*MEM_WORDS] = '{default: 8'h00};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_size   (p0_size),
        .p0_uns    (p0_uns),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_err    (p0_err),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_size   (p1_size),
        .p1_uns    (p1_uns),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_err    (p1_err),
        .p1_rdata  (p1_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory stand-in: read register holds its value during writes.
    always @(posedge clk) begin
        if (mem_we)
            tmem[mem_addr] <= mem_wdata;
        else if (mem_re)
            tmem_rd <= tmem[mem_addr];
    end
    assign mem_rdata = tmem_rd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Little-endian byte-array view of memory; loads assemble bytes
    // arithmetically and sign-extend by subtracting 2^(8n).
    task automatic model(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic e_err,
                         output logic [31:0] e_rd, output int e_lat);
        longint a, v;
        int n;
        a = longint'(addr);
        n = 1 << size;
        e_err = (size == 2'd3) || (a % n != 0) || (a >= 4 * MEM_WORDS);
        e_rd = 32'h0;
        if (e_err) begin
            e_lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++)
                rb[a + i] = wdata[8*i +: 8];
            e_lat = (n == 4) ? 1 : 2;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++)
                v += longint'(rb[a + i]) << (8 * i);
            if (!uns && v >= (longint'(1) << (8 * n - 1)))
                v -= longint'(1) << (8 * n);
            e_rd = v[31:0];
            e_lat = 2;
        end
    endtask

    task automatic drive(input bit port, input logic req, input logic we,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_size = size;
            p1_uns = uns; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_size = size;
            p0_uns = uns; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic run(input bit port, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err,
                       output logic [31:0] rd, output int lat,
                       output logic [AW-1:0] g_addr, output logic g_we,
                       output logic g_re, output logic side_bad,
                       output logic any_mem);
        logic own_ack, oth;
        @(posedge clk); #1;
        drive(port, 1'b1, we, size, uns, addr, wdata);
        @(negedge clk);
        g_addr = mem_addr; g_we = mem_we; g_re = mem_re;
        side_bad = (mem_we & mem_re) | p0_ack | p1_ack;
        any_mem = mem_we | mem_re;
        err = 1'b0; rd = 32'h0; lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            any_mem |= mem_we | mem_re;
            side_bad |= mem_we & mem_re;
            own_ack = port ? p1_ack : p0_ack;
            oth = port ? (p0_ack | p0_err | (|p0_rdata))
                       : (p1_ack | p1_err | (|p1_rdata));
            side_bad |= oth;
            if (own_ack) begin
                lat = k;
                err = port ? p1_err : p0_err;
                rd  = port ? p1_rdata : p0_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        bit          port;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
        int          lat;
        logic        mwe;
        logic        mre;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic          m_err, a_err, g_we, g_re, sb, am, both;
        logic [31:0]   m_rd, a_rd, e0, e1;
        logic [AW-1:0] g_addr;
        int            m_lat, a_lat, n;
        int            got [4];
        bit            rp;
        logic          rwe, runs;
        logic [1:0]    rsz;
        logic [31:0]   raddr, rwd;

        tbl[0]  = '{0, 1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        1, 1, 0};
        tbl[1]  = '{0, 0, 2'd2, 0, 32'h10,   32'h0,        0, 32'hDEADBEEF, 2, 0, 1};
        tbl[2]  = '{0, 1, 2'd0, 0, 32'h11,   32'h123456A5, 0, 32'h0,        2, 0, 1};
        tbl[3]  = '{0, 0, 2'd2, 0, 32'h10,   32'h0,        0, 32'hDEADA5EF, 2, 0, 1};
        tbl[4]  = '{0, 0, 2'd0, 0, 32'h11,   32'h0,        0, 32'hFFFFFFA5, 2, 0, 1};
        tbl[5]  = '{0, 0, 2'd0, 1, 32'h11,   32'h0,        0, 32'h000000A5, 2, 0, 1};
        tbl[6]  = '{0, 1, 2'd1, 0, 32'h12,   32'hABCD8001, 0, 32'h0,        2, 0, 1};
        tbl[7]  = '{1, 0, 2'd2, 0, 32'h10,   32'h0,        0, 32'h8001A5EF, 2, 0, 1};
        tbl[8]  = '{1, 0, 2'd1, 0, 32'h12,   32'h0,        0, 32'hFFFF8001, 2, 0, 1};
        tbl[9]  = '{1, 0, 2'd1, 1, 32'h10,   32'h0,        0, 32'h0000A5EF, 2, 0, 1};
        tbl[10] = '{0, 0, 2'd1, 0, 32'h13,   32'h0,        1, 32'h0,        1, 0, 0};
        tbl[11] = '{0, 1, 2'd2, 0, 32'h2000, 32'h11111111, 1, 32'h0,        1, 0, 0};
        tbl[12] = '{1, 0, 2'd3, 0, 32'h10,   32'h0,        1, 32'h0,        1, 0, 0};
        tbl[13] = '{1, 1, 2'd2, 0, 32'h1FFC, 32'h13579BDF, 0, 32'h0,        1, 1, 0};
        tbl[14] = '{0, 0, 2'd0, 0, 32'h1FFF, 32'h0,        0, 32'h00000013, 2, 0, 1};
        tbl[15] = '{0, 0, 2'd2, 0, 32'h1FFE, 32'h0,        1, 32'h0,        1, 0, 0};

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {30'h0, p1_ack, p0_ack}, 32'h0);
        chk("rst_err", {30'h0, p1_err, p0_err}, 32'h0);
        chk("rst_rdata0", p0_rdata, 32'h0);
        chk("rst_rdata1", p1_rdata, 32'h0);
        chk("rst_mem", {30'h0, mem_we, mem_re}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                  tbl[i].wdata, m_err, m_rd, m_lat);
            run(tbl[i].port, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                tbl[i].wdata, a_err, a_rd, a_lat, g_addr, g_we, g_re, sb, am);
            chk($sformatf("tbl%0d_err", i), a_err, tbl[i].err);
            chk($sformatf("tbl%0d_rdata", i), a_rd, tbl[i].rd);
            chk($sformatf("tbl%0d_lat", i), a_lat, tbl[i].lat);
            chk($sformatf("tbl%0d_grant_we", i), g_we, tbl[i].mwe);
            chk($sformatf("tbl%0d_grant_re", i), g_re, tbl[i].mre);
            chk($sformatf("tbl%0d_side", i), sb, 1'b0);
            if (!tbl[i].err)
                chk($sformatf("tbl%0d_maddr", i), g_addr, tbl[i].addr[AW+1:2]);
            else
                chk($sformatf("tbl%0d_nomem", i), am, 1'b0);
        end

        // Reset while a byte store sits in MERGE: write must be abandoned.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000003C);
        @(negedge clk);
        chk("abort_grant_re", mem_re, 1'b1);
        @(negedge clk);
        chk("abort_merge_we", mem_we, 1'b1);
        #2 rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        chk("abort_we_drop", mem_we, 1'b0);
        chk("abort_outs", {23'h0, p0_ack, p1_ack, p0_err, p1_err, mem_re,
            |p0_rdata, |p1_rdata, |mem_addr, |mem_wdata}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, m_err, m_rd, m_lat);
        run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,
            a_err, a_rd, a_lat, g_addr, g_we, g_re, sb, am);
        chk("abort_word_kept", a_rd, m_rd);
        chk("abort_next_lat", a_lat, m_lat);

        // Both ports request continuously from reset.
        model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, m_err, e0, m_lat);
        model(1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0, m_err, e1, m_lat);
        @(posedge clk); #1 rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0);
        #1 chk("cont_rst_quiet", {28'h0, mem_we, mem_re, p0_ack, p1_ack}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        got = '{-1, -1, -1, -1};
        n = 0;
        both = 1'b0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (p0_ack && p1_ack) begin
                both = 1'b1;
            end else if (p0_ack) begin
                got[n] = 0;
                n++;
                chk("cont_rdata0", p0_rdata, e0);
                both |= p1_err | (|p1_rdata);
            end else if (p1_ack) begin
                got[n] = 1;
                n++;
                chk("cont_rdata1", p1_rdata, e1);
                both |= p0_err | (|p0_rdata);
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cont_order%0d", i), got[i], i % 2);
        chk("cont_exclusive", both, 1'b0);

        // Random traffic against the byte-array model.
        for (int i = 0; i < 200; i++) begin
            rp   = 1'($urandom_range(1, 0));
            rwe  = 1'($urandom_range(1, 0));
            runs = 1'($urandom_range(1, 0));
            n    = $urandom_range(9, 0);
            rsz  = (n == 9) ? 2'd3 : 2'(n % 3);
            n    = $urandom_range(9, 0);
            if (n == 0)
                raddr = $urandom;
            else if (n == 1)
                raddr = 32'h1FF0 + $urandom_range(15, 0);
            else
                raddr = $urandom_range(63, 0);
            rwd = $urandom;
            model(rwe, rsz, runs, raddr, rwd, m_err, m_rd, m_lat);
            run(rp, rwe, rsz, runs, raddr, rwd,
                a_err, a_rd, a_lat, g_addr, g_we, g_re, sb, am);
            chk($sformatf("rnd%0d_err", i), a_err, m_err);
            chk($sformatf("rnd%0d_rdata", i), a_rd, m_rd);
            chk($sformatf("rnd%0d_lat", i), a_lat, m_lat);
            chk($sformatf("rnd%0d_side", i), sb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
